// File: rtl/slsr_load_ctrl.sv
// slsr_load_ctrl: sequencer for one SerialLoadSR instance.
// Takes a parallel word on a valid/ready command port and shifts it in MSB-first on sr_d/sr_e.
// The displaced old contents are captured from sr_q and returned on a valid/ready response port.
// Optional feature macro SLSR_LOAD_CTRL_TXN_COUNT_EN adds a saturating 16-bit handshake counter.
module slsr_load_ctrl #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned GAP   = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             sr_d,
  output logic             sr_e,
  input  logic             sr_q,
  output logic             busy
`ifdef SLSR_LOAD_CTRL_TXN_COUNT_EN
  ,
  output logic [15:0]      txn_count
`endif
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // Gap counter runs 0..GAP-1; keep at least one bit so GAP=0/1 still elaborate.
  localparam int unsigned GapW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [IdxW-1:0] IdxTop  = IdxW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StWait,
    StResp
  } state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] w_shadow_next;
  logic [WIDTH-1:0] r_capture;
  logic [WIDTH-1:0] w_capture_next;
  logic [IdxW-1:0]  r_idx;
  logic [IdxW-1:0]  w_idx_next;
  logic [GapW-1:0]  r_gap_cnt;
  logic [GapW-1:0]  w_gap_next;

  // State and datapath registers; clr abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= StIdle;
      r_shadow  <= '0;
      r_capture <= '0;
      r_idx     <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_shadow  <= w_shadow_next;
      r_capture <= w_capture_next;
      r_idx     <= w_idx_next;
      r_gap_cnt <= w_gap_next;
    end
  end

  // Next-state logic and state-decoded outputs; sr_* depend only on registered state.
  always_comb begin
    w_state_next   = r_state;
    w_shadow_next  = r_shadow;
    w_capture_next = r_capture;
    w_idx_next     = r_idx;
    w_gap_next     = r_gap_cnt;
    cmd_ready      = 1'b0;
    rsp_valid      = 1'b0;
    sr_e           = 1'b0;
    sr_d           = 1'b0;
    busy           = 1'b1;
    unique case (r_state)
      StIdle: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          w_shadow_next  = cmd_data;
          w_capture_next = '0;
          w_idx_next     = IdxTop;
          w_gap_next     = '0;
          w_state_next   = StShift;
        end
      end
      StShift: begin
        sr_e = 1'b1;
        sr_d = r_shadow[r_idx];
        // Q still shows the pre-edge last stage, i.e. old bit r_idx.
        w_capture_next[r_idx] = sr_q;
        if (r_idx == '0) begin
          w_state_next = StResp;
        end else begin
          w_idx_next = r_idx - IdxW'(1);
          if (GAP > 0) begin
            w_state_next = StWait;
          end
        end
      end
      StWait: begin
        if (r_gap_cnt == GapLast) begin
          w_gap_next   = '0;
          w_state_next = StShift;
        end else begin
          w_gap_next = r_gap_cnt + GapW'(1);
        end
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  assign rsp_data = r_capture;

`ifdef SLSR_LOAD_CTRL_TXN_COUNT_EN
  logic [15:0] r_txn_count;

  // Count completed response handshakes, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_txn_count <= '0;
    end else if (rsp_valid && rsp_ready && (r_txn_count != 16'hFFFF)) begin
      r_txn_count <= r_txn_count + 16'd1;
    end
  end

  assign txn_count = r_txn_count;
`endif

endmodule

// File: tb/tb_slsr_load_ctrl.sv
// Bench for slsr_load_ctrl: two instances (GAP=0 and GAP=2), each driving a behavioural
// SerialLoadSR model; expected responses are queued at issue time and checked by monitors.
module tb_slsr_load_ctrl;

  localparam int unsigned W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr;

  logic         a_cmd_valid, a_cmd_ready, a_rsp_valid, a_rsp_ready;
  logic         a_sr_d, a_sr_e, a_sr_q, a_busy;
  logic [W-1:0] a_cmd_data, a_rsp_data, a_sr;
  logic         b_cmd_valid, b_cmd_ready, b_rsp_valid, b_rsp_ready;
  logic         b_sr_d, b_sr_e, b_sr_q, b_busy;
  logic [W-1:0] b_cmd_data, b_rsp_data, b_sr;
`ifdef SLSR_LOAD_CTRL_TXN_COUNT_EN
  logic [15:0]  a_txn_count, b_txn_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] q_a[$];
  logic [W-1:0] q_b[$];

  slsr_load_ctrl #(.WIDTH(W), .GAP(0)) u_dut (
    .clk       (clk),
    .clr       (clr),
    .cmd_valid (a_cmd_valid),
    .cmd_ready (a_cmd_ready),
    .cmd_data  (a_cmd_data),
    .rsp_valid (a_rsp_valid),
    .rsp_ready (a_rsp_ready),
    .rsp_data  (a_rsp_data),
    .sr_d      (a_sr_d),
    .sr_e      (a_sr_e),
    .sr_q      (a_sr_q),
    .busy      (a_busy)
`ifdef SLSR_LOAD_CTRL_TXN_COUNT_EN
    ,
    .txn_count (a_txn_count)
`endif
  );

  slsr_load_ctrl #(.WIDTH(W), .GAP(2)) u_dut_gap (
    .clk       (clk),
    .clr       (clr),
    .cmd_valid (b_cmd_valid),
    .cmd_ready (b_cmd_ready),
    .cmd_data  (b_cmd_data),
    .rsp_valid (b_rsp_valid),
    .rsp_ready (b_rsp_ready),
    .rsp_data  (b_rsp_data),
    .sr_d      (b_sr_d),
    .sr_e      (b_sr_e),
    .sr_q      (b_sr_q),
    .busy      (b_busy)
`ifdef SLSR_LOAD_CTRL_TXN_COUNT_EN
    ,
    .txn_count (b_txn_count)
`endif
  );

  // SerialLoadSR models: stage 1 is bit 0, Q is the last stage.
  always @(posedge clk) begin
    if (clr) a_sr <= '0;
    else if (a_sr_e) a_sr <= {a_sr[W-2:0], a_sr_d};
  end
  always @(posedge clk) begin
    if (clr) b_sr <= '0;
    else if (b_sr_e) b_sr <= {b_sr[W-2:0], b_sr_d};
  end
  assign a_sr_q = a_sr[W-1];
  assign b_sr_q = b_sr[W-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitors: a handshake visible mid-cycle completes at the next edge.
  always @(negedge clk) begin
    if (!clr && a_rsp_valid && a_rsp_ready) begin
      if (q_a.size() == 0) check("a_unexpected_rsp", 32'(a_rsp_valid), 32'd0);
      else check("a_rsp_data", 32'(a_rsp_data), 32'(q_a.pop_front()));
    end
  end
  always @(negedge clk) begin
    if (!clr && b_rsp_valid && b_rsp_ready) begin
      if (q_b.size() == 0) check("b_unexpected_rsp", 32'(b_rsp_valid), 32'd0);
      else check("b_rsp_data", 32'(b_rsp_data), 32'(q_b.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a command, wait (bounded) for acceptance; returns just after the accept edge.
  task automatic send_a(input logic [W-1:0] data, input bit exp_rsp, input logic [W-1:0] exp);
    int i;
    a_cmd_data  = data;
    a_cmd_valid = 1'b1;
    i = 0;
    while (!a_cmd_ready && i < 64) begin
      tick(1);
      i++;
    end
    check("a_cmd_accept", 32'(a_cmd_ready), 32'd1);
    if (exp_rsp) q_a.push_back(exp);
    tick(1);
    a_cmd_valid = 1'b0;
  endtask

  task automatic send_b(input logic [W-1:0] data, input logic [W-1:0] exp);
    int i;
    b_cmd_data  = data;
    b_cmd_valid = 1'b1;
    i = 0;
    while (!b_cmd_ready && i < 64) begin
      tick(1);
      i++;
    end
    check("b_cmd_accept", 32'(b_cmd_ready), 32'd1);
    q_b.push_back(exp);
    tick(1);
    b_cmd_valid = 1'b0;
  endtask

  // Record 16 cycles of sr_e, sr_d and busy; d_seq collects sr_d on shift cycles.
  task automatic observe(input bit sel, output logic [15:0] e_pat, output logic [15:0] d_pat,
                         output logic [15:0] d_seq, output logic [15:0] b_pat);
    logic e, d;
    e_pat = '0;
    d_pat = '0;
    d_seq = '0;
    b_pat = '0;
    for (int k = 0; k < 16; k++) begin
      e = sel ? b_sr_e : a_sr_e;
      d = sel ? b_sr_d : a_sr_d;
      e_pat[k] = e;
      d_pat[k] = d;
      b_pat[k] = sel ? b_busy : a_busy;
      if (e) d_seq = {d_seq[14:0], d};
      tick(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] e_pat, d_pat, d_seq, b_pat;
    int i;
    clr         = 1'b1;
    a_cmd_valid = 1'b0;
    a_cmd_data  = '0;
    a_rsp_ready = 1'b1;
    b_cmd_valid = 1'b0;
    b_cmd_data  = '0;
    b_rsp_ready = 1'b1;

    // Reset state
    tick(2);
    check("rst_cmd_ready", 32'(a_cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(a_rsp_data), 32'd0);
    check("rst_sr_e", 32'(a_sr_e), 32'd0);
    check("rst_sr_d", 32'(a_sr_d), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    clr = 1'b0;
    tick(1);

    // Load after reset
    send_a(5'b10110, 1'b1, 5'b00000);
    observe(1'b0, e_pat, d_pat, d_seq, b_pat);
    check("load1_sr_e", 32'(e_pat), 32'h001F);
    check("load1_sr_d", 32'(d_seq), 32'b10110);
    check("load1_busy", 32'(b_pat), 32'h003F);

    // Readback of previous words
    send_a(5'b01011, 1'b1, 5'b10110);
    observe(1'b0, e_pat, d_pat, d_seq, b_pat);
    check("load2_sr_d", 32'(d_seq), 32'b01011);
    check("load2_sr_e", 32'(e_pat), 32'h001F);
    send_a(5'b11001, 1'b1, 5'b01011);
    observe(1'b0, e_pat, d_pat, d_seq, b_pat);
    check("load3_sr_d", 32'(d_seq), 32'b11001);

    // Gap pacing on the GAP=2 instance
    send_b(5'b11111, 5'b00000);
    observe(1'b1, e_pat, d_pat, d_seq, b_pat);
    check("gap_sr_e", 32'(e_pat), 32'h1249);
    check("gap_sr_d", 32'(d_pat), 32'h1249);
    check("gap_busy", 32'(b_pat), 32'h3FFF);

    // Backpressure with a new command held pending
    a_rsp_ready = 1'b0;
    send_a(5'b00111, 1'b1, 5'b11001);
    a_cmd_data  = 5'b10000;
    a_cmd_valid = 1'b1;
    i = 0;
    while (!a_rsp_valid && i < 32) begin
      tick(1);
      i++;
    end
    check("bp_rsp_rise", 32'(a_rsp_valid), 32'd1);
    for (int k = 0; k < 10; k++) begin
      check("bp_rsp_valid", 32'(a_rsp_valid), 32'd1);
      check("bp_rsp_data", 32'(a_rsp_data), 32'b11001);
      check("bp_cmd_ready", 32'(a_cmd_ready), 32'd0);
      check("bp_sr_e", 32'(a_sr_e), 32'd0);
      tick(1);
    end
    a_rsp_ready = 1'b1;
    q_a.push_back(5'b00111);
    tick(1);
    check("bp_idle_cmd_ready", 32'(a_cmd_ready), 32'd1);
    check("bp_idle_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("bp_idle_busy", 32'(a_busy), 32'd0);
    tick(1);
    a_cmd_valid = 1'b0;
    check("bp_accept_sr_e", 32'(a_sr_e), 32'd1);
    check("bp_accept_busy", 32'(a_busy), 32'd1);
    tick(8);

    // Reset on the third shift cycle: no response, SR cleared
    send_a(5'b10101, 1'b0, 5'b00000);
    tick(2);
    check("mid_in_shift", 32'(a_sr_e), 32'd1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("mid_sr_e", 32'(a_sr_e), 32'd0);
    check("mid_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("mid_cmd_ready", 32'(a_cmd_ready), 32'd1);
    tick(10);
    send_a(5'b01110, 1'b1, 5'b00000);
    tick(8);

`ifdef SLSR_LOAD_CTRL_TXN_COUNT_EN
    clr = 1'b1;
    tick(2);
    clr = 1'b0;
    check("txn_reset", 32'(a_txn_count), 32'd0);
    send_a(5'b10001, 1'b1, 5'b00000);
    tick(8);
    send_a(5'b00011, 1'b1, 5'b10001);
    tick(8);
    send_a(5'b00100, 1'b1, 5'b00011);
    tick(8);
    check("txn_three", 32'(a_txn_count), 32'd3);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("txn_cleared", 32'(a_txn_count), 32'd0);
    send_a(5'b11000, 1'b1, 5'b00000);
    tick(8);
    check("txn_one", 32'(a_txn_count), 32'd1);
`endif

    tick(4);
    check("a_queue_drained", 32'(q_a.size()), 32'd0);
    check("b_queue_drained", 32'(q_b.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
